// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file burst sequencer.
//   DW_DEFAULT / AW_DEFAULT : default data and address widths
//   OP_*                    : command opcode encodings on cmd_op
//   state_e                 : sequencer FSM states
package regfile_seq_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 3;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_DRAIN = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StLoad,
        StDrain
    } state_e;

endpackage

// File: rtl/regfile_seq_rf_out_reg.sv
// One-entry valid/ready output register carrying data plus a last flag.
//   clk, clear_n            : clock, async active-low reset
//   loadEn                  : capture loadData/loadLast this cycle
//   loadData, loadLast      : beat to capture
//   canLoad                 : register is empty or being drained this cycle
//   out_valid, out_ready    : downstream handshake
//   out_data, out_last      : registered beat, stable while stalled
module regfile_seq_rf_out_reg
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          loadEn,
    input  logic [DW-1:0] loadData,
    input  logic          loadLast,
    output logic          canLoad,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    logic          validQ;
    logic [DW-1:0] dataQ;
    logic          lastQ;

    assign canLoad = !validQ || out_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            validQ <= 1'b0;
            dataQ  <= '0;
            lastQ  <= 1'b0;
        end else if (loadEn) begin
            validQ <= 1'b1;
            dataQ  <= loadData;
            lastQ  <= loadLast;
        end else if (out_ready) begin
            // Beat consumed with nothing behind it; data is kept but invalid.
            validQ <= 1'b0;
        end
    end

    assign out_valid = validQ;
    assign out_data  = dataQ;
    assign out_last  = lastQ;

endmodule

// File: rtl/regfile_seq.sv
// Burst sequencer in front of a DEPTH-entry register file.
//   clk, clear_n                      : clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_addr/cmd_len                  : command port (CLEAR, LOAD, DRAIN)
//   in_valid/in_ready/in_data         : LOAD write stream
//   out_valid/out_ready/out_data/
//   out_last                          : DRAIN read stream
//   rf_enable/rf_clear/rf_RW/rf_addr/
//   rf_dataIn/rf_dataOut              : register-file control and data
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          rf_enable,
    output logic          rf_clear,
    output logic          rf_RW,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_dataIn,
    input  logic [DW-1:0] rf_dataOut
);

    state_e        stateQ;
    logic [AW-1:0] ptrQ;
    logic [AW-1:0] remQ;

    logic inFire;
    logic canLoad;
    logic fetch;
    logic lastDone;

    assign inFire   = (stateQ == StLoad) && in_valid;
    // Stop reading once the last beat sits in the output register.
    assign fetch    = (stateQ == StDrain) && canLoad && !(out_valid && out_last);
    assign lastDone = out_valid && out_ready && out_last;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            stateQ <= StIdle;
            ptrQ   <= '0;
            remQ   <= '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_CLEAR: stateQ <= StClr;
                            OP_LOAD: begin
                                stateQ <= StLoad;
                                ptrQ   <= cmd_addr;
                                remQ   <= cmd_len;
                            end
                            OP_DRAIN: begin
                                stateQ <= StDrain;
                                ptrQ   <= cmd_addr;
                                remQ   <= cmd_len;
                            end
                            default: stateQ <= StIdle;
                        endcase
                    end
                end
                StClr: stateQ <= StIdle;
                StLoad: begin
                    if (in_valid) begin
                        ptrQ <= ptrQ + 1'b1;
                        if (remQ == '0) begin
                            stateQ <= StIdle;
                        end else begin
                            remQ <= remQ - 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (fetch) begin
                        ptrQ <= ptrQ + 1'b1;
                        if (remQ != '0) begin
                            remQ <= remQ - 1'b1;
                        end
                    end
                    if (lastDone) begin
                        stateQ <= StIdle;
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    regfile_seq_rf_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk      (clk),
        .clear_n  (clear_n),
        .loadEn   (fetch),
        .loadData (rf_dataOut),
        .loadLast (remQ == '0),
        .canLoad  (canLoad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    // State is held at StIdle and ptr at zero during reset, so only the
    // reset-gated outputs need clear_n explicitly.
    assign cmd_ready = clear_n && (stateQ == StIdle);
    assign in_ready  = (stateQ == StLoad);
    assign rf_enable = clear_n;
    assign rf_clear  = (stateQ == StClr);
    assign rf_RW     = inFire;
    assign rf_addr   = ptrQ;
    assign rf_dataIn = (stateQ == StLoad) ? in_data : '0;

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;

    logic       clk;
    logic       clear_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       rf_enable;
    logic       rf_clear;
    logic       rf_RW;
    logic [2:0] rf_addr;
    logic [7:0] rf_dataIn;
    logic [7:0] rf_dataOut;

    int nChecks;
    int nFails;

    logic [7:0] d [8];
    logic [7:0] mem [8];

    regfile_seq #(
        .DW(8),
        .AW(3)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .rf_enable (rf_enable),
        .rf_clear  (rf_clear),
        .rf_RW     (rf_RW),
        .rf_addr   (rf_addr),
        .rf_dataIn (rf_dataIn),
        .rf_dataOut(rf_dataOut)
    );

    // 8x8 register file: synchronous write/clear, combinational read.
    always @(posedge clk) begin
        if (rf_enable) begin
            if (rf_clear) begin
                for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            end else if (rf_RW) begin
                mem[rf_addr] <= rf_dataIn;
            end
        end
    end
    assign rf_dataOut = mem[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers a command and returns at the negedge after it is accepted.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [2:0] len);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        nChecks++;
        if (cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the negedge of the first cycle in DRAIN. mode 0: ready held
    // high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_drain(input logic [2:0] len, input logic [7:0] exp [8], input int mode);
        int k;
        int c;
        logic stalled;
        logic [7:0] hd;
        logic hl;
        k = 0;
        c = 1;
        stalled = 1'b0;
        hd = 8'h00;
        hl = 1'b0;
        out_ready = 1'b0;
        #1;
        nChecks++;
        if (out_valid !== 1'b0) begin
            nFails++;
            $display("FAIL drain_first_cycle_valid: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        while (k <= int'(len) && c < 64) begin
            out_ready = (mode == 0) ? 1'b1 : (c % 3 == 1);
            #1;
            if (stalled) begin
                nChecks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
                    nFails++;
                    $display("FAIL drain_stall_stable: valid=%b data=%h last=%b required 1 %h %b",
                             out_valid, out_data, out_last, hd, hl);
                end
            end
            if (mode == 0) begin
                nChecks++;
                if (out_valid !== 1'b1) begin
                    nFails++;
                    $display("FAIL drain_consecutive: beat %0d out_valid=%b required 1",
                             k, out_valid);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                nChecks++;
                if (out_data !== exp[k] || out_last !== (k == int'(len))) begin
                    nFails++;
                    $display("FAIL drain_beat%0d: data=%h last=%b required %h %b", k, out_data,
                             out_last, exp[k], (k == int'(len)));
                end
                k++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        nChecks++;
        if (k <= int'(len)) begin
            nFails++;
            $display("FAIL drain_timeout: %0d beats received required %0d", k, int'(len) + 1);
        end
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL drain_end: out_valid=%b cmd_ready=%b required 0 1", out_valid, cmd_ready);
        end
    endtask

    task automatic load_burst(input logic [2:0] addr, input logic [2:0] len);
        do_cmd(2'b01, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 1) begin
                // One idle cycle mid-burst: must stall without writing.
                in_valid = 1'b0;
                #1;
                nChecks++;
                if (rf_RW !== 1'b0 || in_ready !== 1'b1) begin
                    nFails++;
                    $display("FAIL load_stall: rf_RW=%b in_ready=%b required 0 1", rf_RW, in_ready);
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = d[i];
            #1;
            nChecks++;
            if (in_ready !== 1'b1 || rf_RW !== 1'b1 || rf_addr !== 3'(int'(addr) + i) ||
                rf_dataIn !== d[i]) begin
                nFails++;
                $display("FAIL load_write%0d: ready=%b RW=%b addr=%0d din=%h required 1 1 %0d %h",
                         i, in_ready, rf_RW, rf_addr, rf_dataIn, 3'(int'(addr) + i), d[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        nChecks++;
        if (in_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL load_end: in_ready=%b cmd_ready=%b required 0 1", in_ready, cmd_ready);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        #12;
        nChecks++;
        if (cmd_ready !== 1'b0 || in_ready !== 1'b0 || rf_enable !== 1'b0 || rf_clear !== 1'b0 ||
            rf_RW !== 1'b0 || rf_addr !== 3'd0 || rf_dataIn !== 8'h00) begin
            nFails++;
            $display("FAIL reset_ctrl: cr=%b ir=%b en=%b clr=%b RW=%b addr=%0d din=%h required 0s",
                     cmd_ready, in_ready, rf_enable, rf_clear, rf_RW, rf_addr, rf_dataIn);
        end
        nChecks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            nFails++;
            $display("FAIL reset_out: valid=%b data=%h last=%b required 0 00 0", out_valid,
                     out_data, out_last);
        end
        in_valid = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        nChecks++;
        if (cmd_ready !== 1'b1 || rf_enable !== 1'b1) begin
            nFails++;
            $display("FAIL reset_release: cmd_ready=%b rf_enable=%b required 1 1", cmd_ready,
                     rf_enable);
        end
        @(negedge clk);
    endtask

    task automatic test_load_drain();
        for (int i = 0; i < 8; i++) d[i] = 8'h10 + 8'(i);
        load_burst(3'd0, 3'd7);
        @(negedge clk);
        do_cmd(2'b10, 3'd0, 3'd7);
        run_drain(3'd7, d, 0);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        load_burst(3'd6, 3'd3);
        nChecks++;
        if (mem[6] !== 8'hA0 || mem[7] !== 8'hA1 || mem[0] !== 8'hA2 || mem[1] !== 8'hA3) begin
            nFails++;
            $display("FAIL wrap_mem: %h %h %h %h required a0 a1 a2 a3", mem[6], mem[7], mem[0],
                     mem[1]);
        end
        @(negedge clk);
        do_cmd(2'b10, 3'd6, 3'd3);
        run_drain(3'd3, d, 0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        // Contents now: A2 A3 12 13 14 15 A0 A1
        d = '{8'hA2, 8'hA3, 8'h12, 8'h13, 8'h14, 8'h15, 8'hA0, 8'hA1};
        do_cmd(2'b10, 3'd0, 3'd7);
        run_drain(3'd7, d, 1);
        @(negedge clk);
    endtask

    task automatic test_clear();
        do_cmd(2'b00, 3'd0, 3'd0);
        #1;
        nChecks++;
        if (rf_clear !== 1'b1 || cmd_ready !== 1'b0) begin
            nFails++;
            $display("FAIL clear_pulse: rf_clear=%b cmd_ready=%b required 1 0", rf_clear, cmd_ready);
        end
        @(negedge clk);
        #1;
        nChecks++;
        if (rf_clear !== 1'b0 || cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL clear_single: rf_clear=%b cmd_ready=%b required 0 1", rf_clear, cmd_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) d[i] = 8'h00;
        do_cmd(2'b10, 3'd0, 3'd7);
        run_drain(3'd7, d, 0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        d = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        do_cmd(2'b01, 3'd0, 3'd7);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(negedge clk);
        end
        in_data = 8'h99;
        clear_n = 1'b0;
        #1;
        nChecks++;
        if (rf_RW !== 1'b0 || in_ready !== 1'b0 || rf_enable !== 1'b0) begin
            nFails++;
            $display("FAIL rst_load_during: RW=%b in_ready=%b en=%b required 0 0 0", rf_RW,
                     in_ready, rf_enable);
        end
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        nChecks++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || rf_RW !== 1'b0) begin
            nFails++;
            $display("FAIL rst_load_release: cmd_ready=%b in_ready=%b RW=%b required 1 0 0",
                     cmd_ready, in_ready, rf_RW);
        end
        @(negedge clk);
        in_valid = 1'b0;
        nChecks++;
        if (mem[0] !== 8'h55 || mem[1] !== 8'h66 || mem[2] !== 8'h77 || mem[3] !== 8'h00) begin
            nFails++;
            $display("FAIL rst_load_mem: %h %h %h %h required 55 66 77 00", mem[0], mem[1], mem[2],
                     mem[3]);
        end
        do_cmd(2'b10, 3'd0, 3'd2);
        run_drain(3'd2, d, 0);
        @(negedge clk);
        // Reset while a drain beat is pending.
        do_cmd(2'b10, 3'd0, 3'd7);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        nChecks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            nFails++;
            $display("FAIL rst_drain_pending: valid=%b data=%h required 1 55", out_valid, out_data);
        end
        clear_n = 1'b0;
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            nFails++;
            $display("FAIL rst_drain_async: valid=%b data=%h last=%b required 0 00 0", out_valid,
                     out_data, out_last);
        end
        @(negedge clk);
        clear_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL rst_drain_after: out_valid=%b cmd_ready=%b required 0 1", out_valid,
                     cmd_ready);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 3'd4;
        cmd_len   = 3'd1;
        #1;
        nChecks++;
        if (cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL b2b_first_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_op   = 2'b10;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'hC4 + 8'(i);
            #1;
            nChecks++;
            if (cmd_ready !== 1'b0 || rf_RW !== 1'b1) begin
                nFails++;
                $display("FAIL b2b_busy%0d: cmd_ready=%b RW=%b required 0 1", i, cmd_ready, rf_RW);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        nChecks++;
        if (cmd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL b2b_second_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        d = '{8'hC4, 8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_drain(3'd1, d, 0);
        @(negedge clk);
    endtask

    task automatic test_reserved();
        do_cmd(2'b11, 3'd2, 3'd5);
        #1;
        nChecks++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || rf_clear !== 1'b0 || out_valid !== 1'b0) begin
            nFails++;
            $display("FAIL reserved_noop: cr=%b ir=%b clr=%b ov=%b required 1 0 0 0", cmd_ready,
                     in_ready, rf_clear, out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        nChecks   = 0;
        nFails    = 0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 3'd0;
        cmd_len   = 3'd0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_load_drain();
        test_wrap();
        test_backpressure();
        test_clear();
        test_reset_mid_burst();
        test_back_to_back();
        test_reserved();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 Parameter DW, 8, data width of one register-file entry.
REQ-002 Parameter AW, 3, register-file address width; DEPTH = 2**AW = 8 entries.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clear_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  00 CLEAR, 01 LOAD, 10 DRAIN, 11 reserved (accepted, treated as no-op).
REQ-008 cmd_addr  input  AW  start address of the burst.
REQ-009 cmd_len  input  AW  burst length minus one (0 = 1 entry, 7 = 8 entries).
REQ-010 in_valid / in_ready / in_data  input / output / input  1/1/DW  LOAD write stream.
REQ-011 out_valid / out_ready / out_data / out_last  output / input / output / output  1/1/DW/1  DRAIN read stream.
REQ-012 rf_enable, rf_clear, rf_RW  output  1 each  register-file control; rf_RW=1 write, 0 read.
REQ-013 rf_addr  output  AW  register-file address; rf_dataIn  output  DW  write data.
REQ-014 rf_dataOut  input  DW  register-file read data, combinational from rf_addr, valid only when rf_RW=0.

Function
REQ-015 FSM states IDLE, CLR, LOAD, DRAIN; cmd_ready=1 only in IDLE; commands offered elsewhere are not accepted.
REQ-016 IDLE + accepted CLEAR -> CLR; CLR drives rf_clear=1 for exactly one cycle, then IDLE.
REQ-017 IDLE + accepted LOAD/DRAIN -> latch ptr=cmd_addr, remaining=cmd_len; go to LOAD/DRAIN; reserved op stays IDLE.
REQ-018 LOAD: in_ready=1; rf_addr=ptr, rf_dataIn=in_data, rf_RW=in_valid (combinational, same cycle); on each in_valid handshake ptr increments mod DEPTH.
REQ-019 LOAD exits to IDLE on the handshake with remaining=0, otherwise remaining decrements; in_valid low stalls with no write.
REQ-020 DRAIN: rf_RW=0, rf_addr=ptr; one-entry output register; when empty or (out_valid && out_ready) it loads rf_dataOut, sets out_valid, out_last=(remaining=0), advances ptr mod DEPTH.
REQ-021 DRAIN read latency: first out_valid one cycle after entering DRAIN; with out_ready held 1, one entry per cycle.
REQ-022 out_data/out_last held stable while out_valid && !out_ready.
REQ-023 DRAIN returns to IDLE when the out_last beat handshakes; out_valid falls the following cycle unless a new beat is loaded.
REQ-024 Address wrap: ptr rolls 7 -> 0; burst never exceeds DEPTH entries.
REQ-025 rf_RW=0 in every state except LOAD with in_valid=1; rf_enable=1 whenever clear_n=1.
REQ-026 in_ready=0 outside LOAD; out_valid=0 outside DRAIN except the final pending beat.

Reset
REQ-027 clear_n low asynchronously forces IDLE, ptr=0, remaining=0, out_valid=0, out_data=0, out_last=0.
REQ-028 During reset outputs are cmd_ready=0, in_ready=0, rf_enable=0, rf_clear=0, rf_RW=0, rf_addr=0, rf_dataIn=0.
REQ-029 Reset mid-LOAD or mid-DRAIN abandons the burst; no further rf writes and no pending out beat after release.
REQ-030 First cycle after release: IDLE with cmd_ready=1.

Structure
REQ-031 Shared package holds op encodings (OP_CLEAR, OP_LOAD, OP_DRAIN), state enum, DW/AW defaults.
REQ-032 Single sub-module natural: rf_out_reg (one-entry valid/ready output register with data+last).
REQ-033 Verification bench instantiates regfile_seq connected to the existing 8x8 register file.

Verification
REQ-034 LOAD addr=0 len=7 data 0x10..0x17, then DRAIN addr=0 len=7, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles, out_last only on 0x17.
REQ-035 LOAD addr=6 len=3 data A0,A1,A2,A3 -> entries 6,7,0,1 written; DRAIN addr=6 len=3 returns A0..A3 (wrap).
REQ-036 DRAIN with out_ready toggled 1,0,0,1... -> no beat lost or duplicated, out_data stable while stalled.
REQ-037 CLEAR after load -> rf_clear high exactly 1 cycle; DRAIN addr=0 len=7 returns eight 0x00.
REQ-038 clear_n pulsed low mid-LOAD after 3 of 8 bytes -> no further writes, IDLE, cmd_ready=1 next cycle after release; entries 0..2 retain data.
REQ-039 cmd_valid held high during LOAD -> cmd_ready=0 until burst completes, second command accepted in the first IDLE cycle.
